// File: rtl/counter_capture_ext_pkg.sv
// Shared constants and FSM encoding for the
// extended-count capture block.
package counter_capture_ext_pkg;

  localparam int CNT_W_D = 8;
  localparam int EXT_W_D = 8;
  localparam int DATA_W  = CNT_W_D + EXT_W_D;

  localparam logic [EXT_W_D-1:0] WRAP_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } cap_state_t;

endpackage

// File: rtl/counter_capture_ext_if.sv
// Snapshot read port: DATA/VALID toward the
// reader, READY back from it.
interface counter_capture_ext_if
  import counter_capture_ext_pkg::*;
#(
  parameter int W = DATA_W
) ();

  logic [W-1:0] DATA;
  logic         VALID;
  logic         READY;

  modport master (
    output DATA,
    output VALID,
    input  READY
  );

  modport slave (
    input  DATA,
    input  VALID,
    output READY
  );

endinterface

// File: rtl/pulse_rise_det.sv
// Rising-edge detector: registers the previous
// level, flags d=1 while the stored level is 0.
module pulse_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/counter_capture_ext.sv
// Extends an 8-bit counter with a saturating wrap
// count and hands snapshots out over valid/ready.
module counter_capture_ext
  import counter_capture_ext_pkg::*;
#(
  parameter int CNT_W = CNT_W_D,
  parameter int EXT_W = EXT_W_D
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             OV_in,
  input  logic             CLR_in,
  input  logic             CAP,
  output logic             SAT,
  output logic             MISS,
  counter_capture_ext_if.master bus
);

  localparam int DW = EXT_W + CNT_W;
  localparam logic [EXT_W-1:0] WMAX = '1;

  cap_state_t       state_q, state_n;
  logic [EXT_W-1:0] wrap_q, wrap_next;
  logic [DW-1:0]    data_q;
  logic             wrap_ev, at_max;
  logic             sat_hit, miss_hit, load;

  pulse_rise_det u_ov_det (
    .clk   (clk),
    .rst_n (Reset),
    .d     (OV_in),
    .rise  (wrap_ev)
  );

  assign at_max  = (wrap_q == WMAX);
  assign sat_hit = wrap_ev & at_max;

  always_comb begin
    wrap_next = wrap_q;
    if (wrap_ev && !at_max)
      wrap_next = wrap_q + 1'b1;
  end

  always_comb begin
    state_n  = state_q;
    load     = 1'b0;
    miss_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CAP) begin
          load    = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.READY && CAP) begin
          load = 1'b1;
        end else if (bus.READY) begin
          state_n = IDLE;
        end else if (CAP) begin
          miss_hit = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      wrap_q  <= '0;
      SAT     <= 1'b0;
      MISS    <= 1'b0;
    end else begin
      state_q <= state_n;
      // snapshot uses wrap_next, so it predates a same-cycle clear
      if (load) data_q <= {wrap_next, counter_in};
      if (CLR_in) begin
        wrap_q <= '0;
        SAT    <= 1'b0;
        MISS   <= 1'b0;
      end else begin
        wrap_q <= wrap_next;
        if (sat_hit)  SAT  <= 1'b1;
        if (miss_hit) MISS <= 1'b1;
      end
    end
  end

  assign bus.DATA  = data_q;
  assign bus.VALID = (state_q == HOLD);

endmodule

// File: doc/counter_capture_ext.md
Name: counter_capture_ext

Overview:
- Downstream consumer of the 8-bit event counter.
- Watches the counter value and its overflow flag, and keeps an overflow (wrap) count to form a 16-bit extended count.
- On a capture request, latches a snapshot and presents it to a software or bus reader over a valid/ready handshake.
- Flags wrap-count saturation and any capture requests dropped while a snapshot is still pending.

Parameters:
- CNT_W, 8: width of the incoming counter value.
- EXT_W, 8: width of the wrap (overflow) counter; DATA width = EXT_W + CNT_W.

Ports:
- clk  input  1  system clock, 10 MHz.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk only.
- counter_in  input  CNT_W  current value from the upstream counter.
- OV_in  input  1  overflow flag from the upstream counter; level, may stay high for more than one cycle.
- CLR_in  input  1  clear; same signal that drives the upstream counter's CLR.
- CAP  input  1  capture request, sampled every cycle.
- READY  input  1  reader accepts DATA this cycle.
- DATA  output  EXT_W+CNT_W  snapshot {wrap_count, counter}, registered.
- VALID  output  1  DATA holds an unread snapshot.
- SAT  output  1  sticky: wrap counter has saturated.
- MISS  output  1  sticky: a CAP was dropped.

Behaviour:
- All state updates on the rising edge of clk. Reset=0 at an edge forces: DATA=0, VALID=0, SAT=0, MISS=0, wrap_count=0, OV edge register=0, FSM=IDLE. Reset has priority over every other input, including mid-handshake; a pending snapshot is discarded.
- Overflow detection: a rising edge of OV_in (OV_in=1 and previous-cycle OV_in=0) is one wrap event. A level held high counts once.
- wrap_next:
  - wrap_count+1 on a wrap event;
  - held when wrap_count is at max (2^EXT_W-1) and a wrap event occurs; SAT is set in that cycle;
  - otherwise wrap_count.
- CLR_in=1: wrap_count<=0, SAT<=0, MISS<=0. A wrap event in the same cycle is discarded. CLR_in does not affect VALID or DATA.
- FSM, two states:
  - IDLE (VALID=0): CAP=1 -> DATA<={wrap_next, counter_in}, go to HOLD. wrap_next is computed before any clear, so a CAP in the same cycle as CLR_in captures the pre-clear value.
  - HOLD (VALID=1): DATA is stable.
    - READY=1 and CAP=0 -> go to IDLE.
    - READY=1 and CAP=1 -> reload DATA with the new snapshot, stay in HOLD (back-to-back, no bubble).
    - READY=0 and CAP=1 -> snapshot dropped, MISS<=1, DATA unchanged.
- Latency: CAP at edge n -> VALID=1 and DATA valid after edge n; the reader sees them during cycle n+1. A transfer occurs on any edge where VALID=1 and READY=1.
- READY while VALID=0 is ignored.
- Width rules: unsigned arithmetic; the wrap counter never wraps (it saturates). The counter_in field is passed through unmodified.

Decomposition:
- Shared package holds: CNT_W/EXT_W defaults, DATA width constant, FSM state encoding (IDLE=1'b0, HOLD=1'b1), wrap-count max constant.
- One sub-module: pulse_rise_det (1-bit registered rising-edge detector with synchronous active-low reset), used for OV_in.
- The rest stays in the top block.

Test Plan:
- Reset, then CAP at counter_in=8'h37 with no prior OV -> next cycle VALID=1, DATA=16'h0037; READY=1 -> VALID=0.
- Three OV_in pulses, the second held high for 4 cycles, then CAP at counter_in=8'h05 -> DATA=16'h0305.
- VALID=1 with READY=0, CAP pulsed -> MISS=1, DATA unchanged. Then READY=1 together with CAP at counter_in=8'h10 -> VALID stays 1, DATA={wrap,8'h10}, MISS stays 1 until CLR_in.
- 256 OV edges -> wrap_count stays 8'hFF, SAT=1; CLR_in -> SAT=0, MISS=0; next CAP at counter_in=0 gives DATA=16'h0000.
- CAP, CLR_in and an OV edge in the same cycle with wrap_count=8'h02 -> DATA[15:8]=8'h03, wrap_count=0 afterwards.
- Reset=0 asserted while VALID=1 and READY=0 -> after the edge VALID=0, DATA=0, all flags 0; Reset pulsed between clock edges has no effect.
